// File: rtl/trafik_pkg.sv
// Shared traffic-light definitions: phase encoding, LED bus patterns and the
// decode/sequence helpers used by both the controller and its monitor.
package trafik_pkg;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_RED  = 2'd1,
    PH_YEL  = 2'd2,
    PH_GRN  = 2'd3
  } phase_t;

  localparam logic [5:0] PAT_RED = 6'b111100;
  localparam logic [5:0] PAT_YEL = 6'b110011;
  localparam logic [5:0] PAT_GRN = 6'b001111;

  // Any bus value other than the three legal patterns decodes to PH_NONE.
  function automatic phase_t pat2phase(input logic [5:0] pat);
    phase_t ph;
    case (pat)
      PAT_RED: ph = PH_RED;
      PAT_YEL: ph = PH_YEL;
      PAT_GRN: ph = PH_GRN;
      default: ph = PH_NONE;
    endcase
    return ph;
  endfunction

  function automatic phase_t next_phase(input phase_t ph);
    phase_t nx;
    case (ph)
      PH_RED:  nx = PH_YEL;
      PH_YEL:  nx = PH_GRN;
      PH_GRN:  nx = PH_RED;
      default: nx = PH_NONE;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every DIV clocks, restartable so the
// next tick lands exactly DIV cycles after a restart.
module tick_prescaler #(
  parameter int unsigned DIV = 13_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/trafik_isik_monitor.sv
// Passive watchdog on the traffic-light LED bus: decodes the phase, times each
// phase in ticks and raises sticky pattern/sequence/duration faults.
module trafik_isik_monitor
  import trafik_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 13_500_000,
  parameter int unsigned RED_TICKS = 20,
  parameter int unsigned YEL_TICKS = 4,
  parameter int unsigned GRN_TICKS = 11,
  parameter int unsigned TOL       = 1,
  parameter int unsigned DUR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       led_in,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_chg,
  output logic [DUR_W-1:0] last_dur,
  output logic             locked,
  output logic             err_pat,
  output logic             err_seq,
  output logic             err_dur,
  output logic             fault
);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic             phase_chg_q, phase_chg_d;
  logic [DUR_W-1:0] last_dur_q, last_dur_d;
  logic             locked_q, locked_d;
  logic             err_pat_q, err_pat_d;
  logic             err_seq_q, err_seq_d;
  logic             err_dur_q, err_dur_d;
  logic             fault_q, fault_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             ovr_q, ovr_d;

  logic             tick, restart;
  phase_t           in_ph;
  logic [DUR_W-1:0] dur_inc;
  logic [DUR_W:0]   dur_x, exp_cur, tol_x, hi, lo;
  logic             set_pat, set_seq, set_dur;

  function automatic logic [DUR_W:0] exp_ticks(input phase_t ph);
    logic [DUR_W:0] e;
    case (ph)
      PH_RED:  e = (DUR_W+1)'(RED_TICKS);
      PH_YEL:  e = (DUR_W+1)'(YEL_TICKS);
      PH_GRN:  e = (DUR_W+1)'(GRN_TICKS);
      default: e = '0;
    endcase
    return e;
  endfunction

  tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    in_ph   = pat2phase(led_in);
    // Include a tick landing this cycle so the count covers every full tick elapsed.
    dur_inc = (&dur_q) ? dur_q : dur_q + DUR_W'(tick);
    dur_x   = {1'b0, dur_inc};
    exp_cur = exp_ticks(phase_q);
    tol_x   = (DUR_W+1)'(TOL);
    hi      = exp_cur + tol_x;
    lo      = (exp_cur > tol_x) ? exp_cur - tol_x : '0;

    state_d     = state_q;
    phase_d     = phase_q;
    phase_chg_d = 1'b0;
    last_dur_d  = last_dur_q;
    locked_d    = locked_q;
    dur_d       = dur_inc;
    ovr_d       = ovr_q;
    restart     = 1'b0;
    set_pat     = 1'b0;
    set_seq     = 1'b0;
    set_dur     = 1'b0;

    if (in_ph == PH_NONE) begin
      set_pat  = 1'b1;
      phase_d  = PH_NONE;
      locked_d = 1'b0;
      state_d  = ST_SYNC;
      restart  = 1'b1;
      dur_d    = '0;
      ovr_d    = 1'b0;
    end else if (phase_q == PH_NONE) begin
      phase_d = in_ph;
      restart = 1'b1;
      dur_d   = '0;
      ovr_d   = 1'b0;
    end else if (in_ph != phase_q) begin
      phase_d     = in_ph;
      phase_chg_d = 1'b1;
      last_dur_d  = dur_inc;
      restart     = 1'b1;
      dur_d       = '0;
      ovr_d       = 1'b0;
      if (state_q == ST_SYNC) begin
        state_d  = ST_RUN;
        locked_d = 1'b1;
      end else begin
        if (in_ph != next_phase(phase_q)) set_seq = 1'b1;
        // A phase already flagged as overrun is not flagged again when it ends.
        if (!ovr_q && (dur_x < lo || dur_x > hi)) set_dur = 1'b1;
      end
    end else if (state_q == ST_RUN && !ovr_q && tick && dur_x == hi + 1'b1) begin
      set_dur = 1'b1;
      ovr_d   = 1'b1;
    end

    err_pat_d = (err_pat_q & ~clr_err) | set_pat;
    err_seq_d = (err_seq_q & ~clr_err) | set_seq;
    err_dur_d = (err_dur_q & ~clr_err) | set_dur;
    fault_d   = err_pat_q | err_seq_q | err_dur_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SYNC;
      phase_q     <= PH_NONE;
      phase_chg_q <= 1'b0;
      last_dur_q  <= '0;
      locked_q    <= 1'b0;
      err_pat_q   <= 1'b0;
      err_seq_q   <= 1'b0;
      err_dur_q   <= 1'b0;
      fault_q     <= 1'b0;
      dur_q       <= '0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      phase_chg_q <= phase_chg_d;
      last_dur_q  <= last_dur_d;
      locked_q    <= locked_d;
      err_pat_q   <= err_pat_d;
      err_seq_q   <= err_seq_d;
      err_dur_q   <= err_dur_d;
      fault_q     <= fault_d;
      dur_q       <= dur_d;
      ovr_q       <= ovr_d;
    end
  end

  assign phase     = phase_q;
  assign phase_chg = phase_chg_q;
  assign last_dur  = last_dur_q;
  assign locked    = locked_q;
  assign err_pat   = err_pat_q;
  assign err_seq   = err_seq_q;
  assign err_dur   = err_dur_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_trafik_isik_monitor.sv
// Scoreboard bench for trafik_isik_monitor with a 4-cycle tick.
module tb_trafik_isik_monitor;
  import trafik_pkg::*;

  localparam int TB_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] led_in;
  logic       clr_err;
  logic [1:0] phase;
  logic       phase_chg;
  logic [7:0] last_dur;
  logic       locked, err_pat, err_seq, err_dur, fault;

  trafik_isik_monitor #(.TICK_DIV(TB_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .led_in    (led_in),
    .clr_err   (clr_err),
    .phase     (phase),
    .phase_chg (phase_chg),
    .last_dur  (last_dur),
    .locked    (locked),
    .err_pat   (err_pat),
    .err_seq   (err_seq),
    .err_dur   (err_dur),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ph;
    logic [7:0] dur;
    bit         chk_dur;
    bit         lk;
    bit         seq;
    bit         derr;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic expect_chg(input phase_t ph, input int dur, input bit chk_dur,
                            input bit lk, input bit seq, input bit derr);
    exp_t e;
    e.ph = ph; e.dur = 8'(dur); e.chk_dur = chk_dur;
    e.lk = lk; e.seq = seq; e.derr = derr;
    sb.push_back(e);
  endtask

  task automatic hold(input logic [5:0] pat, input int n);
    led_in = pat;
    repeat (n * TB_DIV) @(posedge clk);
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"},     phase,     0);
    chk({tag, "_phase_chg"}, phase_chg, 0);
    chk({tag, "_last_dur"},  last_dur,  0);
    chk({tag, "_locked"},    locked,    0);
    chk({tag, "_err_pat"},   err_pat,   0);
    chk({tag, "_err_seq"},   err_seq,   0);
    chk({tag, "_err_dur"},   err_dur,   0);
    chk({tag, "_fault"},     fault,     0);
  endtask

  // Monitor: every phase_chg pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && phase_chg === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_phase_chg", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("chg_phase", phase, e.ph);
          if (e.chk_dur) chk("chg_last_dur", last_dur, e.dur);
          chk("chg_locked",  locked,  e.lk);
          chk("chg_err_seq", err_seq, e.seq);
          chk("chg_err_dur", err_dur, e.derr);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; clr_err = 1'b0; led_in = PAT_RED;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Nominal cycle; first phase after reset is partial and not timed.
    hold(PAT_RED, 3);
    expect_chg(PH_YEL, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      hold(PAT_YEL, 4);  expect_chg(PH_GRN, 4, 1, 1, 0, 0);
      hold(PAT_GRN, 11); expect_chg(PH_RED, 11, 1, 1, 0, 0);
      hold(PAT_RED, 20); expect_chg(PH_YEL, 20, 1, 1, 0, 0);
    end
    chk("nominal_fault", fault, 0);
    chk("nominal_locked", locked, 1);

    // Yellow overrun: flag at tick 6, fault one cycle later, single set.
    hold(PAT_YEL, 6);
    chk("ovr_before", err_dur, 0);
    step;
    chk("ovr_err_dur", err_dur, 1);
    chk("ovr_fault_lag", fault, 0);
    step;
    chk("ovr_fault", fault, 1);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("clr_err_dur", err_dur, 0);
    step;
    chk("clr_fault", fault, 0);
    expect_chg(PH_GRN, 7, 1, 1, 0, 0);

    // Out-of-order RED->GRN.
    hold(PAT_GRN, 11); expect_chg(PH_RED, 11, 1, 1, 0, 0);
    hold(PAT_RED, 20); expect_chg(PH_GRN, 20, 1, 1, 1, 0);
    led_in = PAT_GRN;
    step;
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("seq_cleared", err_seq, 0);
    chk("seq_phase", phase, 3);

    // One-cycle illegal pattern mid-GREEN.
    repeat (8) @(posedge clk);
    #1 led_in = 6'b000000;
    step;
    chk("pat_err_pat", err_pat, 1);
    chk("pat_phase", phase, 0);
    chk("pat_locked", locked, 0);
    led_in = PAT_RED;
    step;
    chk("pat_resync_phase", phase, 1);
    chk("pat_resync_locked", locked, 0);
    chk("pat_resync_seq", err_seq, 0);
    hold(PAT_RED, 5);
    expect_chg(PH_GRN, 0, 0, 1, 0, 0);

    // clr_err coinciding with a GREEN overrun: set wins.
    led_in  = PAT_GRN;
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("clr_err_pat", err_pat, 0);
    repeat (51) @(posedge clk);
    #1;
    chk("grn_ovr_before", err_dur, 0);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("clr_vs_set_err_dur", err_dur, 1);
    expect_chg(PH_RED, 13, 1, 1, 0, 1);
    hold(PAT_RED, 20);
    expect_chg(PH_YEL, 20, 1, 1, 0, 1);

    // Asynchronous reset mid-YELLOW, then a partial first phase.
    led_in = PAT_YEL;
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    #1 rst = 1'b1;
    hold(PAT_YEL, 1);  expect_chg(PH_GRN, 0, 0, 1, 0, 0);
    hold(PAT_GRN, 11); expect_chg(PH_RED, 11, 1, 1, 0, 0);
    hold(PAT_RED, 2);
    chk("end_err_dur", err_dur, 0);
    chk("end_err_seq", err_seq, 0);
    chk("end_fault", fault, 0);
    chk("end_phase", phase, 1);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
